// File: rtl/fc_pkg.sv
// Shared state encoding and fixed-point round/saturate helper for the
// fully-connected and convolution layers.
package fc_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eSHIFT,
    eBIAS,
    eSCALE,
    eDONE
  } fc_state_e;

  // acc is a sign-extended accumulator (up to 64 bits); the result fits word_size bits.
  function automatic logic signed [63:0] fc_round_sat(
    input logic signed [63:0] acc,
    input int                 n_size,
    input int                 word_size
  );
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (acc + (64'sd1 <<< (n_size - 1))) >>> n_size;
    max_v   = (64'sd1 <<< (word_size - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (word_size - 1));
    if (rounded > max_v) begin
      return max_v;
    end else if (rounded < min_v) begin
      return min_v;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/fc_layer_par_if.sv
// Input-beat, output-vector and weight-write handshakes of the parallel FC layer.
interface fc_layer_par_if #(
  parameter int WORD_SIZE             = 16,
  parameter int LAYER_HEIGHT          = 4,
  parameter int PREVIOUS_LAYER_HEIGHT = 8,
  parameter int LANES                 = 2
);
  localparam int W_ADDR_W = $clog2(LAYER_HEIGHT) + $clog2(PREVIOUS_LAYER_HEIGHT + 1);

  logic [LANES*WORD_SIZE-1:0]        data_i;
  logic                              valid_i;
  logic                              ready_o;
  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_o;
  logic                              valid_o;
  logic                              yumi_i;
  logic                              w_en_i;
  logic [W_ADDR_W-1:0]               w_addr_i;
  logic [WORD_SIZE-1:0]              w_data_i;
  logic                              w_ready_o;

  modport master (
    output data_i, valid_i, yumi_i, w_en_i, w_addr_i, w_data_i,
    input  ready_o, data_o, valid_o, w_ready_o
  );

  modport slave (
    input  data_i, valid_i, yumi_i, w_en_i, w_addr_i, w_data_i,
    output ready_o, data_o, valid_o, w_ready_o
  );
endinterface

// File: rtl/fc_neuron_lanes.sv
// One neuron: per-lane weight RAMs (bias in lane 0), lane multipliers, sum,
// wide accumulator and rounded/saturated output register.
module fc_neuron_lanes
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int N_SIZE                = 8,
  parameter int PREVIOUS_LAYER_HEIGHT = 8,
  parameter int LANES                 = 2,
  parameter int RELU_EN               = 1,
  parameter int LAYER_NUMBER          = 7,
  localparam int BEATS = PREVIOUS_LAYER_HEIGHT / LANES,
  localparam int AW    = $clog2(BEATS + 1),
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [LANES*WORD_SIZE-1:0] data_i,
  input  logic [AW-1:0]              rd_addr_i,
  input  logic                       mac_en_i,
  input  logic                       bias_en_i,
  input  logic                       scale_en_i,
  input  logic                       clr_i,
  input  logic                       w_en_i,
  input  logic [LW-1:0]              w_lane_i,
  input  logic [AW-1:0]              w_beat_i,
  input  logic [WORD_SIZE-1:0]       w_data_i,
  output logic [WORD_SIZE-1:0]       data_o
);
  localparam int ACC_W = 2 * WORD_SIZE + $clog2(PREVIOUS_LAYER_HEIGHT + 1);
  // Tag kept for weight-image preload flows; no effect on the datapath.
  localparam int unused_layer_tag = LAYER_NUMBER;

  logic [LANES*2*WORD_SIZE-1:0] prod_flat;
  logic signed [ACC_W-1:0]      acc_reg, acc_next, beat_sum;
  logic [WORD_SIZE-1:0]         out_reg, out_next;
  logic signed [63:0]           rounded;

  // The read address is the beat to be consumed next, so weight_reg is ready at the handshake.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int DEPTH = (gi == 0) ? BEATS + 1 : BEATS;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] weight_reg;
    logic [IW-1:0]        ra;
    logic                 wr;

    assign wr = w_en_i && (w_lane_i == LW'(gi)) && (int'(w_beat_i) < DEPTH);
    assign ra = (int'(rd_addr_i) < DEPTH) ? IW'(rd_addr_i) : '0;

    always_ff @(posedge clk_i) begin
      if (wr) begin
        mem[IW'(w_beat_i)] <= w_data_i;
      end
      weight_reg <= (wr && (IW'(w_beat_i) == ra)) ? w_data_i : mem[ra];
    end

    assign prod_flat[gi*2*WORD_SIZE +: 2*WORD_SIZE] =
      $signed(data_i[gi*WORD_SIZE +: WORD_SIZE]) * $signed(weight_reg);
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum += ACC_W'($signed(prod_flat[l*2*WORD_SIZE +: 2*WORD_SIZE]));
    end

    acc_next = acc_reg;
    if (clr_i) begin
      acc_next = '0;
    end else if (mac_en_i) begin
      acc_next = acc_reg + beat_sum;
    end else if (bias_en_i) begin
      acc_next = acc_reg + (ACC_W'($signed(g_lane[0].weight_reg)) <<< N_SIZE);
    end

    rounded  = fc_round_sat(64'(acc_reg), N_SIZE, WORD_SIZE);
    out_next = out_reg;
    if (scale_en_i) begin
      out_next = rounded[WORD_SIZE-1:0];
      if ((RELU_EN != 0) && out_next[WORD_SIZE-1]) begin
        out_next = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_reg <= '0;
      out_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      out_reg <= out_next;
    end
  end

  assign data_o = out_reg;
endmodule

// File: rtl/fc_layer_par.sv
// Multi-lane fully-connected layer: beat FSM, weight write decode and one
// fc_neuron_lanes per output neuron.
module fc_layer_par
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int N_SIZE                = 8,
  parameter int LAYER_HEIGHT          = 4,
  parameter int PREVIOUS_LAYER_HEIGHT = 8,
  parameter int LANES                 = 2,
  parameter int RELU_EN               = 1,
  parameter int LAYER_NUMBER          = 7
) (
  input logic            clk_i,
  input logic            reset_i,
  fc_layer_par_if.slave  bus
);
  localparam int BEATS = PREVIOUS_LAYER_HEIGHT / LANES;
  localparam int AW    = $clog2(BEATS + 1);
  localparam int NW    = $clog2(LAYER_HEIGHT);
  localparam int EW    = $clog2(PREVIOUS_LAYER_HEIGHT + 1);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  fc_state_e state_reg, state_next;
  logic [AW-1:0] beat_cnt_reg, beat_cnt_next, rd_addr;
  logic          in_fire, out_fire, last_beat;
  logic [EW-1:0] elem_idx;
  int            neuron_sel;
  logic          wr_ok;
  logic [LW-1:0] wr_lane;
  logic [AW-1:0] wr_beat;
  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_all;

  assign bus.ready_o   = (state_reg == eIDLE) || (state_reg == eSHIFT);
  assign bus.valid_o   = (state_reg == eDONE);
  assign bus.w_ready_o = ((state_reg == eIDLE) && !bus.valid_i) || (state_reg == eDONE);
  assign bus.data_o    = data_all;

  assign in_fire   = bus.valid_i && bus.ready_o;
  assign out_fire  = (state_reg == eDONE) && bus.yumi_i;
  assign last_beat = (beat_cnt_reg == AW'(BEATS - 1));

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      eIDLE, eSHIFT: begin
        if (in_fire) begin
          beat_cnt_next = beat_cnt_reg + AW'(1);
          state_next    = last_beat ? eBIAS : eSHIFT;
        end
      end
      eBIAS:  state_next = eSCALE;
      eSCALE: state_next = eDONE;
      eDONE: begin
        if (bus.yumi_i) begin
          state_next    = eIDLE;
          beat_cnt_next = '0;
        end
      end
      default: begin
        state_next    = eIDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg    <= eIDLE;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // After the last beat the address lands on BEATS, which is the bias word of lane 0.
  assign rd_addr  = reset_i ? '0 : beat_cnt_next;
  assign elem_idx = bus.w_addr_i[EW-1:0];

  if (NW > 0) begin : g_sel
    assign neuron_sel = int'(bus.w_addr_i[EW +: NW]);
  end else begin : g_no_sel
    assign neuron_sel = 0;
  end

  always_comb begin
    wr_ok = bus.w_en_i && bus.w_ready_o && (neuron_sel < LAYER_HEIGHT) &&
            (int'(elem_idx) <= PREVIOUS_LAYER_HEIGHT);
    if (int'(elem_idx) == PREVIOUS_LAYER_HEIGHT) begin
      wr_lane = '0;
      wr_beat = AW'(BEATS);
    end else begin
      wr_lane = LW'(int'(elem_idx) % LANES);
      wr_beat = AW'(int'(elem_idx) / LANES);
    end
  end

  for (genvar gi = 0; gi < LAYER_HEIGHT; gi++) begin : g_neuron
    fc_neuron_lanes #(
      .WORD_SIZE             (WORD_SIZE),
      .N_SIZE                (N_SIZE),
      .PREVIOUS_LAYER_HEIGHT (PREVIOUS_LAYER_HEIGHT),
      .LANES                 (LANES),
      .RELU_EN               (RELU_EN),
      .LAYER_NUMBER          (LAYER_NUMBER)
    ) u_neuron (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .data_i     (bus.data_i),
      .rd_addr_i  (rd_addr),
      .mac_en_i   (in_fire),
      .bias_en_i  (state_reg == eBIAS),
      .scale_en_i (state_reg == eSCALE),
      .clr_i      (out_fire),
      .w_en_i     (wr_ok && (neuron_sel == gi)),
      .w_lane_i   (wr_lane),
      .w_beat_i   (wr_beat),
      .w_data_i   (bus.w_data_i),
      .data_o     (data_all[gi*WORD_SIZE +: WORD_SIZE])
    );
  end
endmodule

// File: tb/tb_fc_layer_par.sv
// Scoreboard bench: two layer instances (ReLU on / off) share stimulus; monitors
// compare every valid output cycle against queued hand-computed vectors.
module tb_fc_layer_par;
  localparam int W = 16;
  localparam int H = 2;
  localparam int P = 4;
  localparam int L = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [L*W-1:0] data = '0;
  logic          valid = 1'b0;
  logic          yumi = 1'b0;
  logic          w_en = 1'b0;
  logic [3:0]    w_addr = '0;
  logic [W-1:0]  w_data = '0;

  int tests = 0;
  int fails = 0;
  int vec_r = 0;
  int vec_s = 0;
  logic [H*W-1:0] exp_r[$];
  logic [H*W-1:0] exp_s[$];

  fc_layer_par_if #(.WORD_SIZE(W), .LAYER_HEIGHT(H), .PREVIOUS_LAYER_HEIGHT(P), .LANES(L)) bus_r ();
  fc_layer_par_if #(.WORD_SIZE(W), .LAYER_HEIGHT(H), .PREVIOUS_LAYER_HEIGHT(P), .LANES(L)) bus_s ();

  assign bus_r.data_i = data;   assign bus_s.data_i = data;
  assign bus_r.valid_i = valid; assign bus_s.valid_i = valid;
  assign bus_r.yumi_i = yumi;   assign bus_s.yumi_i = yumi;
  assign bus_r.w_en_i = w_en;   assign bus_s.w_en_i = w_en;
  assign bus_r.w_addr_i = w_addr; assign bus_s.w_addr_i = w_addr;
  assign bus_r.w_data_i = w_data; assign bus_s.w_data_i = w_data;

  fc_layer_par #(.WORD_SIZE(W), .N_SIZE(8), .LAYER_HEIGHT(H), .PREVIOUS_LAYER_HEIGHT(P),
                 .LANES(L), .RELU_EN(1), .LAYER_NUMBER(7))
    u_dut_relu (.clk_i(clk), .reset_i(reset), .bus(bus_r.slave));
  fc_layer_par #(.WORD_SIZE(W), .N_SIZE(8), .LAYER_HEIGHT(H), .PREVIOUS_LAYER_HEIGHT(P),
                 .LANES(L), .RELU_EN(0), .LAYER_NUMBER(7))
    u_dut_sgn (.clk_i(clk), .reset_i(reset), .bus(bus_s.slave));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare on every valid cycle (checks hold stability), pop on consume.
  always @(negedge clk) begin
    if (!reset && bus_r.valid_o === 1'b1) begin
      if (exp_r.size() == 0) begin
        tests++; fails++;
        $display("FAIL relu_unexpected_valid: got data_o %h with empty queue", bus_r.data_o);
      end else begin
        check("relu_data_o", bus_r.data_o, exp_r[0]);
        if (yumi) begin
          $display("[TB] relu vector %0d data_o=%h", vec_r, bus_r.data_o);
          vec_r++;
          void'(exp_r.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus_s.valid_o === 1'b1) begin
      if (exp_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL sgn_unexpected_valid: got data_o %h with empty queue", bus_s.data_o);
      end else begin
        check("sgn_data_o", bus_s.data_o, exp_s[0]);
        if (yumi) begin
          $display("[TB] signed vector %0d data_o=%h", vec_s, bus_s.data_o);
          vec_s++;
          void'(exp_s.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready_r"}, 32'(bus_r.ready_o), 32'd1);
    check({tag, "_valid_r"}, 32'(bus_r.valid_o), 32'd0);
    check({tag, "_data_r"}, bus_r.data_o, 32'd0);
    check({tag, "_wready_r"}, 32'(bus_r.w_ready_o), 32'd1);
    check({tag, "_ready_s"}, 32'(bus_s.ready_o), 32'd1);
    check({tag, "_valid_s"}, 32'(bus_s.valid_o), 32'd0);
    check({tag, "_data_s"}, bus_s.data_o, 32'd0);
    check({tag, "_wready_s"}, 32'(bus_s.w_ready_o), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; yumi = 1'b0; w_en = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input int n, input int e, input logic [W-1:0] d);
    w_en = 1'b1; w_addr = {1'(n), 3'(e)}; w_data = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic load_neuron(input int n, input logic [W-1:0] wt, input logic [W-1:0] b);
    for (int e = 0; e < P; e++) write_word(n, e, wt);
    write_word(n, P, b);
  endtask

  task automatic push_exp(input logic [W-1:0] r0, input logic [W-1:0] r1,
                          input logic [W-1:0] s0, input logic [W-1:0] s1);
    exp_r.push_back({r1, r0});
    exp_s.push_back({s1, s0});
  endtask

  task automatic send_beat(input logic [W-1:0] lo, input logic [W-1:0] hi);
    int k = 0;
    data = {hi, lo}; valid = 1'b1;
    while (bus_r.ready_o !== 1'b1 && k < 50) begin tick(); k++; end
    if (k >= 50) check("beat_accept_timeout", 32'(k), 32'd0);
    tick();
    valid = 1'b0;
  endtask

  task automatic vector(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] a3, input int gap);
    int c = 0;
    send_beat(a0, a1);
    repeat (gap) begin
      check("ready_in_gap", 32'(bus_r.ready_o), 32'd1);
      tick();
    end
    send_beat(a2, a3);
    while (bus_r.valid_o !== 1'b1 && c < 20) begin tick(); c++; end
    check("latency_edges", 32'(c), 32'd2);
  endtask

  task automatic finish_vec(input int hold);
    repeat (hold) begin
      check("ready_in_done", 32'(bus_r.ready_o), 32'd0);
      check("wready_in_done", 32'(bus_s.w_ready_o), 32'd1);
      tick();
    end
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    check("valid_after_yumi", 32'(bus_s.valid_o), 32'd0);
  endtask

  initial begin
    do_reset();
    check_idle("reset");

    // Tests 1/2: n0 = 10.5, n1 negative (ReLU clamps it on the relu instance).
    load_neuron(0, 16'd256, 16'd128);
    load_neuron(1, 16'hFF00, 16'd0);
    push_exp(16'd2688, 16'd0, 16'd2688, 16'hF600);
    vector(16'd256, 16'd512, 16'd768, 16'd1024, 0);
    finish_vec(1);

    // Test 3: positive and negative saturation.
    load_neuron(0, 16'h7FFF, 16'h7FFF);
    load_neuron(1, 16'h7FFF, 16'h7FFF);
    push_exp(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vector(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
    finish_vec(0);
    push_exp(16'd0, 16'd0, 16'h8000, 16'h8000);
    vector(16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
    finish_vec(0);

    // Test 4: restore weights, out-of-range writes dropped, gapped beats, slow consumer.
    load_neuron(0, 16'd256, 16'd128);
    load_neuron(1, 16'hFF00, 16'd0);
    for (int e = P + 1; e < 8; e++) begin
      write_word(0, e, 16'h1234);
      write_word(1, e, 16'h1234);
    end
    push_exp(16'd2688, 16'd0, 16'd2688, 16'hF600);
    vector(16'd256, 16'd512, 16'd768, 16'd1024, 3);
    finish_vec(5);

    // Test 5: reset mid-vector leaves no residue and keeps weights.
    send_beat(16'd256, 16'd512);
    do_reset();
    check_idle("midreset");
    push_exp(16'd2688, 16'd0, 16'd2688, 16'hF600);
    vector(16'd256, 16'd512, 16'd768, 16'd1024, 0);
    finish_vec(0);

    // Test 6: write in eSHIFT dropped; bias write in eDONE keeps held output.
    push_exp(16'd2688, 16'd0, 16'd2688, 16'hF600);
    send_beat(16'd256, 16'd512);
    w_en = 1'b1; w_addr = {1'b0, 3'd4}; w_data = 16'd0;
    check("wready_in_shift_r", 32'(bus_r.w_ready_o), 32'd0);
    check("wready_in_shift_s", 32'(bus_s.w_ready_o), 32'd0);
    tick();
    w_en = 1'b0;
    send_beat(16'd768, 16'd1024);
    begin
      int c = 0;
      while (bus_r.valid_o !== 1'b1 && c < 20) begin tick(); c++; end
      check("latency_edges_t6", 32'(c), 32'd2);
    end
    check("wready_done_before_write", 32'(bus_r.w_ready_o), 32'd1);
    write_word(0, P, 16'd0);
    finish_vec(2);
    push_exp(16'd2560, 16'd0, 16'd2560, 16'hF600);
    vector(16'd256, 16'd512, 16'd768, 16'd1024, 0);
    finish_vec(0);

    repeat (3) tick();
    check("scoreboard_empty_r", 32'(exp_r.size()), 32'd0);
    check("scoreboard_empty_s", 32'(exp_s.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
